// File: rtl/gcd_unit_if.sv
// Host-side handshake bundle for the GCD engine: operand request, abort,
// and the result/status returned by the engine.
interface gcd_unit_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = WIDTH + 1
);

  logic             start;
  logic             abort;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero_err;
  logic [CNT_W-1:0] cycles;

  // Host / sequencer side.
  modport master (
    output start, abort, a_in, b_in,
    input  ready, busy, done, result, zero_err, cycles
  );

  // GCD engine side.
  modport slave (
    input  start, abort, a_in, b_in,
    output ready, busy, done, result, zero_err, cycles
  );

endinterface

// File: rtl/gcd_unit.sv
// Parametrised GCD engine: controller FSM with integrated operand datapath.
// MODE 0 runs subtractive Euclid, MODE 1 runs binary Stein (common factors
// of two are stripped into k and restored on the result). Each CALC cycle
// is one evaluation. The result, zero_err and cycles outputs are held from
// one completed run to the next; an aborted run leaves them untouched.
module gcd_unit #(
  parameter int WIDTH = 16,
  parameter int MODE  = 0,
  parameter int CNT_W = WIDTH + 1
) (
  input logic       clk,
  input logic       rst,
  gcd_unit_if.slave bus
);

  localparam int K_W = $clog2(WIDTH) + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [K_W-1:0]   K_ONE   = {{(K_W-1){1'b0}}, 1'b1};

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [K_W-1:0]   k_q, k_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             zero_err_q, zero_err_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;

  // Evaluation count including the current one, pinned at the top value.
  logic [CNT_W-1:0] cnt_inc;
  // Operands with the stripped power of two restored (binary mode only).
  logic [WIDTH-1:0] a_res;
  logic [WIDTH-1:0] b_res;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign a_res   = (MODE == 1) ? (a_q << k_q) : a_q;
  assign b_res   = (MODE == 1) ? (b_q << k_q) : b_q;

  // Next-state and datapath update: one evaluation per CALC cycle.
  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    state_d    = state_q;
    a_d        = a_q;
    b_d        = b_q;
    k_d        = k_q;
    cnt_d      = cnt_q;
    result_d   = result_q;
    zero_err_d = zero_err_q;
    cycles_d   = cycles_q;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          a_d     = bus.a_in;
          b_d     = bus.b_in;
          k_d     = '0;
          cnt_d   = '0;
          state_d = ST_CALC;
        end
      end

      ST_CALC: begin
        if (bus.abort) begin
          // Abort beats termination; published outputs stay as they were.
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (a_q == '0 && b_q == '0) begin
            result_d   = '0;
            zero_err_d = 1'b1;
            cycles_d   = cnt_inc;
            state_d    = ST_DONE;
          end else if (a_q == '0) begin
            result_d   = b_res;
            zero_err_d = 1'b0;
            cycles_d   = cnt_inc;
            state_d    = ST_DONE;
          end else if (b_q == '0) begin
            result_d   = a_res;
            zero_err_d = 1'b0;
            cycles_d   = cnt_inc;
            state_d    = ST_DONE;
          end else if (a_q == b_q) begin
            result_d   = a_res;
            zero_err_d = 1'b0;
            cycles_d   = cnt_inc;
            state_d    = ST_DONE;
          end else if (MODE == 0) begin
            // Always larger minus smaller, so no underflow.
            if (a_q > b_q) begin
              a_d = a_q - b_q;
            end else begin
              b_d = b_q - a_q;
            end
          end else begin
            if (!a_q[0] && !b_q[0]) begin
              a_d = a_q >> 1;
              b_d = b_q >> 1;
              k_d = k_q + K_ONE;
            end else if (!a_q[0]) begin
              a_d = a_q >> 1;
            end else if (!b_q[0]) begin
              b_d = b_q >> 1;
            end else if (a_q > b_q) begin
              a_d = a_q - b_q;
            end else begin
              b_d = b_q - a_q;
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with asynchronous active-high reset.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      state_q    <= ST_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      k_q        <= '0;
      cnt_q      <= '0;
      result_q   <= '0;
      zero_err_q <= 1'b0;
      cycles_q   <= '0;
    end else begin
      state_q    <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      k_q        <= k_d;
      cnt_q      <= cnt_d;
      result_q   <= result_d;
      zero_err_q <= zero_err_d;
      cycles_q   <= cycles_d;
    end
  end

  assign bus.ready    = (state_q == ST_IDLE);
  assign bus.busy     = (state_q == ST_CALC);
  assign bus.done     = (state_q == ST_DONE);
  assign bus.result   = result_q;
  assign bus.zero_err = zero_err_q;
  assign bus.cycles   = cycles_q;

endmodule

// File: tb/tb_gcd_unit.sv
// Self-checking bench for gcd_unit: three instances (Euclid W16, Stein W16,
// Euclid W8 with a 4-bit saturating counter) driven by directed and random
// operand pairs, checked against a behavioural GCD / evaluation-count model.
module tb_gcd_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start_v [3];
  logic        abort_v;
  logic [15:0] a_v;
  logic [15:0] b_v;

  logic        ready_o  [3];
  logic        busy_o   [3];
  logic        done_o   [3];
  logic        zerr_o   [3];
  logic [15:0] result_o [3];
  logic [16:0] cycles_o [3];

  always #5 clk = ~clk;

  gcd_unit_if #(.WIDTH(16), .CNT_W(17)) if0 ();
  gcd_unit_if #(.WIDTH(16), .CNT_W(17)) if1 ();
  gcd_unit_if #(.WIDTH(8),  .CNT_W(4))  if2 ();

  assign if0.start = start_v[0];
  assign if0.abort = abort_v;
  assign if0.a_in  = a_v;
  assign if0.b_in  = b_v;
  assign if1.start = start_v[1];
  assign if1.abort = abort_v;
  assign if1.a_in  = a_v;
  assign if1.b_in  = b_v;
  assign if2.start = start_v[2];
  assign if2.abort = abort_v;
  assign if2.a_in  = a_v[7:0];
  assign if2.b_in  = b_v[7:0];

  assign ready_o[0]  = if0.ready;
  assign busy_o[0]   = if0.busy;
  assign done_o[0]   = if0.done;
  assign zerr_o[0]   = if0.zero_err;
  assign result_o[0] = if0.result;
  assign cycles_o[0] = if0.cycles;
  assign ready_o[1]  = if1.ready;
  assign busy_o[1]   = if1.busy;
  assign done_o[1]   = if1.done;
  assign zerr_o[1]   = if1.zero_err;
  assign result_o[1] = if1.result;
  assign cycles_o[1] = if1.cycles;
  assign ready_o[2]  = if2.ready;
  assign busy_o[2]   = if2.busy;
  assign done_o[2]   = if2.done;
  assign zerr_o[2]   = if2.zero_err;
  assign result_o[2] = {8'd0, if2.result};
  assign cycles_o[2] = {13'd0, if2.cycles};

  gcd_unit #(.WIDTH(16), .MODE(0), .CNT_W(17)) u_euclid (
    .clk (clk),
    .rst (rst),
    .bus (if0.slave)
  );

  gcd_unit #(.WIDTH(16), .MODE(1), .CNT_W(17)) u_stein (
    .clk (clk),
    .rst (rst),
    .bus (if1.slave)
  );

  gcd_unit #(.WIDTH(8), .MODE(0), .CNT_W(4)) u_small (
    .clk (clk),
    .rst (rst),
    .bus (if2.slave)
  );

  int checks = 0;
  int errors = 0;

  int unsigned mode_of [3] = '{0, 1, 0};
  int unsigned cnt_max [3] = '{131071, 131071, 15};
  int unsigned op_mask [3] = '{32'hffff, 32'hffff, 32'hff};

  // Last completed-run values each instance should be holding.
  int unsigned last_res  [3] = '{0, 0, 0};
  int unsigned last_cyc  [3] = '{0, 0, 0};
  int unsigned last_zerr [3] = '{0, 0, 0};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Mathematical GCD via the remainder form (gcd(0,0) = 0).
  function automatic int unsigned gcd_ref(input int unsigned a, input int unsigned b);
    int unsigned t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  // Subtractive Euclid performs sum-of-quotients minus one subtractions,
  // plus one final evaluation that sees equal operands.
  function automatic int unsigned euclid_evals(input int unsigned a, input int unsigned b);
    int unsigned n = 0;
    int unsigned t;
    if (a == 0 || b == 0) return 1;
    while (b != 0) begin
      n += a / b;
      t = a % b;
      a = b;
      b = t;
    end
    return n;
  endfunction

  // Binary GCD step count from the reduction rules.
  function automatic int unsigned stein_evals(input int unsigned a, input int unsigned b);
    int unsigned n = 1;
    if (a == 0 || b == 0) return 1;
    while (a != b) begin
      n++;
      if (a % 2 == 0 && b % 2 == 0) begin a /= 2; b /= 2; end
      else if (a % 2 == 0) a /= 2;
      else if (b % 2 == 0) b /= 2;
      else if (a > b) a -= b;
      else b -= a;
    end
    return n;
  endfunction

  task automatic check_held(input string tag, input int sel);
    check({tag, "_ready"},  ready_o[sel],  1);
    check({tag, "_busy"},   busy_o[sel],   0);
    check({tag, "_done"},   done_o[sel],   0);
    check({tag, "_result"}, result_o[sel], last_res[sel]);
    check({tag, "_zerr"},   zerr_o[sel],   last_zerr[sel]);
    check({tag, "_cycles"}, cycles_o[sel], last_cyc[sel]);
  endtask

  // One full run; mid > 0 pulses a spurious start after that many edges.
  task automatic run_op(input string tag, input int sel, input int unsigned a_raw,
                        input int unsigned b_raw, input int mid);
    int unsigned a, b, exp_evals, exp_res, exp_zerr, exp_cyc;
    int edges;
    int ok;
    a         = a_raw & op_mask[sel];
    b         = b_raw & op_mask[sel];
    exp_evals = (mode_of[sel] == 0) ? euclid_evals(a, b) : stein_evals(a, b);
    exp_res   = gcd_ref(a, b);
    exp_zerr  = (a == 0 && b == 0) ? 1 : 0;
    exp_cyc   = (exp_evals > cnt_max[sel]) ? cnt_max[sel] : exp_evals;

    @(negedge clk);
    check({tag, "_ready_in"}, ready_o[sel], 1);
    a_v          = a_raw[15:0];
    b_v          = b_raw[15:0];
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1 start_v[sel] = 1'b0;
    edges = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (mid > 0 && edges == mid) begin
        start_v[sel] = 1'b1;
        a_v = 16'd7;
        b_v = 16'd7;
      end else begin
        start_v[sel] = 1'b0;
      end
    end while (done_o[sel] !== 1'b1 && edges < int'(exp_evals) + 20);
    start_v[sel] = 1'b0;

    check({tag, "_done_seen"}, done_o[sel],   1);
    check({tag, "_latency"},   edges,         exp_evals);
    check({tag, "_result"},    result_o[sel], exp_res);
    check({tag, "_zerr"},      zerr_o[sel],   exp_zerr);
    check({tag, "_cycles"},    cycles_o[sel], exp_cyc);
    check({tag, "_busy_dn"},   busy_o[sel],   0);
    check({tag, "_ready_dn"},  ready_o[sel],  0);
    last_res[sel]  = exp_res;
    last_zerr[sel] = exp_zerr;
    last_cyc[sel]  = exp_cyc;

    @(negedge clk);
    check({tag, "_done_1cyc"}, done_o[sel],  0);
    check({tag, "_ready_ret"}, ready_o[sel], 1);

    if (mid > 0) begin
      ok = 1;
      repeat (4) begin
        @(negedge clk);
        if (done_o[sel] !== 1'b0 || ready_o[sel] !== 1'b1) ok = 0;
      end
      check({tag, "_no_second_done"}, ok, 1);
    end
  endtask

  // Start a run and assert abort so it is sampled at evaluation edge 'at'.
  task automatic abort_op(input string tag, input int sel, input int unsigned a,
                          input int unsigned b, input int at);
    @(negedge clk);
    a_v          = a[15:0];
    b_v          = b[15:0];
    start_v[sel] = 1'b1;
    @(posedge clk);
    #1 start_v[sel] = 1'b0;
    for (int e = 1; e <= at; e++) begin
      if (e == at) abort_v = 1'b1;
      @(posedge clk);
      #1;
    end
    abort_v = 1'b0;
    @(negedge clk);
    check_held(tag, sel);
    @(negedge clk);
    check({tag, "_still_no_done"}, done_o[sel], 0);
  endtask

  initial begin
    int unsigned ra, rb;
    for (int s = 0; s < 3; s++) start_v[s] = 1'b0;
    abort_v = 1'b0;
    a_v     = '0;
    b_v     = '0;

    // Reset values while rst is held.
    #12;
    for (int s = 0; s < 3; s++) check_held($sformatf("reset_%0d", s), s);
    @(negedge clk);
    rst = 1'b0;

    // Basic runs with hand-derived constants alongside the model.
    run_op("m0_12_8", 0, 12, 8, 0);
    check("m0_12_8_res_const", result_o[0], 4);
    check("m0_12_8_cyc_const", cycles_o[0], 3);
    run_op("m1_12_8", 1, 12, 8, 0);
    check("m1_12_8_res_const", result_o[1], 4);
    check("m1_12_8_cyc_const", cycles_o[1], 6);

    // Zero operands, then a normal pair clears zero_err.
    for (int s = 0; s < 2; s++) begin
      run_op($sformatf("zero_a_%0d", s), s, 0, 35, 0);
      run_op($sformatf("zero_b_%0d", s), s, 35, 0, 0);
      run_op($sformatf("zero_ab_%0d", s), s, 0, 0, 0);
      check($sformatf("zero_ab_flag_%0d", s), zerr_o[s], 1);
      run_op($sformatf("after_zero_%0d", s), s, 9, 6, 0);
      check($sformatf("after_zero_res_%0d", s), result_o[s], 3);
    end

    // Worst case with an ignored mid-run start; saturating counter on W8.
    run_op("worst_w16", 0, 255, 1, 100);
    check("worst_w16_cyc_const", cycles_o[0], 255);
    run_op("worst_w8", 2, 255, 1, 50);
    check("worst_w8_sat_const", cycles_o[2], 15);
    run_op("stein_big", 1, 16'hfff0, 16'h0030, 7);

    // Abort mid-run keeps prior outputs; immediate restart completes.
    run_op("pre_abort", 0, 12, 8, 0);
    abort_op("abort_ev2", 0, 100, 75, 2);
    run_op("post_abort", 0, 100, 75, 0);
    check("post_abort_res_const", result_o[0], 25);
    // Abort on the same edge as a terminating condition wins.
    abort_op("abort_term", 1, 5, 5, 1);
    run_op("post_abort_term", 1, 5, 5, 0);

    // Randomised operand pairs against the model.
    for (int i = 0; i < 20; i++) begin
      for (int s = 0; s < 3; s++) begin
        ra = $urandom_range(0, 1000);
        rb = $urandom_range(1, 1000);
        if ($urandom_range(0, 7) == 0) ra = 0;
        run_op($sformatf("rand_%0d_%0d", s, i), s, ra, rb, 0);
      end
    end

    // Asynchronous reset between clock edges in the middle of a run.
    @(negedge clk);
    a_v        = 16'd255;
    b_v        = 16'd1;
    start_v[0] = 1'b1;
    @(posedge clk);
    #1 start_v[0] = 1'b0;
    repeat (10) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    for (int s = 0; s < 3; s++) begin
      last_res[s]  = 0;
      last_zerr[s] = 0;
      last_cyc[s]  = 0;
    end
    check_held("mid_rst_0", 0);
    check_held("mid_rst_1", 1);
    @(negedge clk);
    rst = 1'b0;
    run_op("after_rst", 0, 9, 6, 0);
    check("after_rst_res_const", result_o[0], 3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
- Self-contained, parametrised GCD engine: a single controller FSM plus an integrated operand datapath with a start/ready/done handshake.
- Successor to the fixed-width controller-plus-external-datapath GCD, generalised in several ways:
  - operand width is a parameter;
  - a compile-time algorithm mode selects subtractive (Euclid) or binary (Stein);
  - adds zero-operand handling, abort, and an iteration counter.
- Sits behind a host/sequencer that issues one operand pair at a time.

Parameters:
WIDTH, 16, operand and result width in bits (>=2)
MODE, 0, 0 = subtractive Euclid, 1 = binary Stein
CNT_W, WIDTH+1, width of iteration counter output

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  request; accepted only when ready=1
abort  input  1  cancel computation in progress
a_in  input  WIDTH  operand A, sampled on accepted start
b_in  input  WIDTH  operand B, sampled on accepted start
ready  output  1  high in IDLE
busy  output  1  high in CALC
done  output  1  one-cycle pulse: result valid
result  output  WIDTH  GCD, held until next accepted start
zero_err  output  1  both operands were zero; held with result
cycles  output  CNT_W  CALC evaluations used (saturating), held with result

Behaviour:
- Reset (async, any state): IDLE; ready=1, busy=0, done=0, result=0, zero_err=0, cycles=0; internal A, B, k cleared.
- States: IDLE, CALC, DONE; 2-bit encoding; no unreachable hold states.
- IDLE:
  - start=1 at a clock edge: A<=a_in, B<=b_in, k<=0, cycle counter<=0, go to CALC.
  - Otherwise stay in IDLE.
- start while not IDLE: ignored, not queued.
- CALC: one evaluation per edge; the counter increments on every evaluation and saturates at 2^CNT_W-1. Priority order:
  1. A=0 and B=0: result<=0, zero_err<=1 -> DONE.
  2. A=0: result<=B; B=0: result<=A (binary mode: shifted left by k); zero_err<=0 -> DONE.
  3. A=B: result<=A (MODE 1: A<<k); zero_err<=0 -> DONE.
  4. MODE 0: if A>B, A<=A-B; else B<=B-A.
  5. MODE 1:
     - both even: A>>=1, B>>=1, k++;
     - else A even: A>>=1;
     - else B even: B>>=1;
     - else larger <= larger-smaller.
- Arithmetic: unsigned, WIDTH bits. Subtraction is always larger minus smaller, so it never underflows. k is clog2(WIDTH)+1 bits, and A<<k never exceeds WIDTH bits.
- DONE: done=1 for exactly one cycle; cycles output <= final count; next edge -> IDLE.
- Latency: start accepted at edge 0; terminating evaluation at edge n (n>=1); done is high in the cycle after edge n; ready returns at edge n+1.
- Back-to-back: start may be accepted on the first IDLE cycle, i.e. one cycle after done.
- abort:
  - Sampled only in CALC: at that edge go to IDLE; no done pulse; result, zero_err and cycles keep their previous values.
  - Ignored in IDLE and DONE.
  - abort and a terminating condition on the same edge: abort wins.
- Reset mid-CALC: immediate return to reset values; no done.

Test Plan:
- MODE 0, WIDTH 16, A=12, B=8 -> done after 3 evaluations; result=4, cycles=3, zero_err=0; done high exactly 1 cycle; ready again 1 cycle later.
- MODE 1, A=12, B=8 -> result=4, cycles=6 (pairs 12/8, 6/4 k=1, 3/2 k=2, 3/1, 2/1, 1/1 -> 1<<2).
- Zero operands: A=0,B=35 -> result=35, cycles=1; A=0,B=0 -> result=0, zero_err=1, cycles=1; next start A=9,B=6 clears zero_err (result=3).
- Worst case MODE 0, WIDTH 8, A=255, B=1 -> result=1, cycles=255; start pulsed mid-run is ignored (result unaffected, no second done).
- Abort at evaluation 2 of A=100, B=75 -> IDLE next cycle, no done, result/cycles retain the prior run's values; an immediately following start with A=100, B=75 yields result=25.
- Async rst asserted mid-CALC, between clock edges -> outputs immediately ready=1, busy=0, done=0, result=0, cycles=0; a fresh start after release computes correctly.
